tx_seq_ctrl: RTL and testbench

//  Single-clock sequencer for the QPSK transmit chain (prbs9 -> tx shaping filter).

---
 rtl/tx_seq_ctrl_pkg.sv | 24 ++
 rtl/tx_seq_ctrl_if.sv | 44 ++++
 rtl/tx_seq_ctrl_os_strobe_gen.sv | 49 ++++
 rtl/tx_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_tx_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_seq_ctrl_pkg.sv
// Shared definitions for the QPSK transmit sequencer.
//   state_e    : sequencer state, encoding is visible on o_state
//   strobes_t  : bundle of the registered per-cycle control strobes
package tx_seq_ctrl_pkg;

    localparam int unsigned ST_W        = 2;
    localparam int unsigned PHASE_SEL_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic prbs_ce;
        logic tx_ce;
        logic tx_zero;
        logic tx_valid;
        logic rx_ce;
    } strobes_t;

endpackage

// File: rtl/tx_seq_ctrl_if.sv
// Control/status bundle between the sequencer and the tx/rx datapath.
//   master : the sequencer (consumes i_*, drives o_*)
//   slave  : the datapath/controller side (drives i_*, consumes o_*)
// Build option TX_SEQ_BURST_EN adds i_burst_len (NB_CNT bits).
interface tx_seq_ctrl_if
    import tx_seq_ctrl_pkg::*;
#(
    parameter int unsigned NB_CNT = 16
) ();

    logic                   i_enable;
    logic [PHASE_SEL_W-1:0] i_phase;
`ifdef TX_SEQ_BURST_EN
    logic [NB_CNT-1:0]      i_burst_len;
`endif
    logic                   o_prbs_ce;
    logic                   o_tx_ce;
    logic                   o_tx_zero;
    logic                   o_tx_valid;
    logic                   o_rx_ce;
    logic [ST_W-1:0]        o_state;
    logic [NB_CNT-1:0]      o_sym_cnt;

`ifdef TX_SEQ_BURST_EN
    modport master (
        input  i_enable, i_phase, i_burst_len,
        output o_prbs_ce, o_tx_ce, o_tx_zero, o_tx_valid, o_rx_ce, o_state, o_sym_cnt
    );
    modport slave (
        output i_enable, i_phase, i_burst_len,
        input  o_prbs_ce, o_tx_ce, o_tx_zero, o_tx_valid, o_rx_ce, o_state, o_sym_cnt
    );
`else
    modport master (
        input  i_enable, i_phase,
        output o_prbs_ce, o_tx_ce, o_tx_zero, o_tx_valid, o_rx_ce, o_state, o_sym_cnt
    );
    modport slave (
        output i_enable, i_phase,
        input  o_prbs_ce, o_tx_ce, o_tx_zero, o_tx_valid, o_rx_ce, o_state, o_sym_cnt
    );
`endif

endinterface

// File: rtl/tx_seq_ctrl_os_strobe_gen.sv
// Oversampling phase counter with symbol-boundary and rx phase-match detects.
//   clk, rst     : clock, synchronous active-low reset
//   run          : 1 = count 0..OS_FACTOR-1 and wrap, 0 = hold at 0
//   phase_sel    : requested rx phase, latched on each symbol boundary (clamped)
//   sb_c         : phase counter is at the last sample of the symbol
//   phase_hit_c  : phase counter equals the latched rx phase
module tx_seq_ctrl_os_strobe_gen
    import tx_seq_ctrl_pkg::*;
#(
    parameter int unsigned OS_FACTOR = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [PHASE_SEL_W-1:0] phase_sel,
    output logic                   sb_c,
    output logic                   phase_hit_c
);

    localparam int unsigned PH_W = $clog2(OS_FACTOR);

    logic [PH_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [PH_W-1:0] phase_q, phase_d;

    // Next phase count and rx phase; the phase only changes at symbol boundaries
    always_comb begin
        sb_c        = (phase_cnt_q == PH_W'(OS_FACTOR - 1));
        phase_hit_c = (phase_cnt_q == phase_q);
        phase_cnt_d = phase_cnt_q + PH_W'(1);
        phase_d     = phase_q;
        if (!run || sb_c) begin
            phase_cnt_d = '0;
        end
        if (sb_c) begin
            phase_d = (32'(phase_sel) >= OS_FACTOR) ? PH_W'(OS_FACTOR - 1) : PH_W'(phase_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_cnt_q <= '0;
            phase_q     <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            phase_q     <= phase_d;
        end
    end

endmodule

// File: rtl/tx_seq_ctrl.sv
// Single-clock QPSK transmit sequencer: IDLE -> FLUSH -> RUN -> DRAIN.
// Generates per-symbol enables for prbs9 and the tx shaping filter from clk,
// forces zero symbols during flush/drain, and produces the rx sampling strobe.
// Strobes are registered: each appears the cycle after the qualifying phase.
//   clk, rst  : clock, synchronous active-low reset
//   bus       : tx_seq_ctrl_if.master (i_enable, i_phase, o_* strobes/status)
// Build option TX_SEQ_BURST_EN: burst length sampled at start, auto-stop after
// that many symbols (0 = continuous), and restart needs a fresh enable rise.
module tx_seq_ctrl
    import tx_seq_ctrl_pkg::*;
#(
    parameter int unsigned OS_FACTOR  = 4,
    parameter int unsigned FLUSH_SYMS = 6,
    parameter int unsigned NB_CNT     = 16
) (
    input  logic          clk,
    input  logic          rst,
    tx_seq_ctrl_if.master bus
);

    localparam int unsigned FL_W = $clog2(FLUSH_SYMS + 1);

    state_e            state_q, state_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [NB_CNT-1:0] sym_cnt_q, sym_cnt_d;
    strobes_t          out_q, out_d;
    logic              sb_c, phase_hit_c, start_c, burst_done_c, flush_last_c;

    tx_seq_ctrl_os_strobe_gen #(.OS_FACTOR(OS_FACTOR)) u_strobe_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (state_q != ST_IDLE),
        .phase_sel  (bus.i_phase),
        .sb_c       (sb_c),
        .phase_hit_c(phase_hit_c)
    );

`ifdef TX_SEQ_BURST_EN
    logic              armed_q, armed_d;
    logic [NB_CNT-1:0] burst_len_q, burst_len_d;

    // Start only on an enable seen low since the last start; burst end on the Nth symbol
    always_comb begin
        start_c      = bus.i_enable && armed_q;
        burst_done_c = (burst_len_q != '0) && (sym_cnt_q == burst_len_q - NB_CNT'(1));
        armed_d      = armed_q || !bus.i_enable;
        burst_len_d  = burst_len_q;
        if (state_q == ST_IDLE && start_c) begin
            armed_d     = 1'b0;
            burst_len_d = bus.i_burst_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed_q     <= 1'b1;
            burst_len_q <= '0;
        end else begin
            armed_q     <= armed_d;
            burst_len_q <= burst_len_d;
        end
    end
`else
    always_comb begin
        start_c      = bus.i_enable;
        burst_done_c = 1'b0;
    end
`endif

    // Next state, counters and strobes; every transition out of a busy state lands on a symbol boundary
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        out_d        = '0;
        flush_last_c = (flush_cnt_q == FL_W'(FLUSH_SYMS - 1));
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                    sym_cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                out_d.tx_zero = 1'b1;
                if (sb_c) begin
                    out_d.tx_ce = 1'b1;
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                    if (flush_last_c) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end
                end
            end
            ST_RUN: begin
                out_d.tx_valid = 1'b1;
                out_d.rx_ce    = phase_hit_c;
                if (sb_c) begin
                    out_d.prbs_ce = 1'b1;
                    out_d.tx_ce   = 1'b1;
                    if (sym_cnt_q != '1) begin
                        sym_cnt_d = sym_cnt_q + NB_CNT'(1);
                    end
                    if (!bus.i_enable || burst_done_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                out_d.tx_zero  = 1'b1;
                out_d.tx_valid = 1'b1;
                out_d.rx_ce    = phase_hit_c;
                if (sb_c) begin
                    out_d.tx_ce = 1'b1;
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                    if (flush_last_c) begin
                        state_d     = ST_IDLE;
                        flush_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            sym_cnt_q   <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            out_q       <= out_d;
        end
    end

    assign bus.o_prbs_ce  = out_q.prbs_ce;
    assign bus.o_tx_ce    = out_q.tx_ce;
    assign bus.o_tx_zero  = out_q.tx_zero;
    assign bus.o_tx_valid = out_q.tx_valid;
    assign bus.o_rx_ce    = out_q.rx_ce;
    assign bus.o_state    = state_q;
    assign bus.o_sym_cnt  = sym_cnt_q;

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Self-checking bench for tx_seq_ctrl (OS_FACTOR=4, FLUSH_SYMS=6, NB_CNT=16).
// Expected o_tx_ce events are queued from the documented latencies when the
// stimulus is applied and matched by a monitor as the strobes appear.
// Inputs are driven and outputs sampled on the falling edge; cyc counts rising edges.
module tb_tx_seq_ctrl;
    import tx_seq_ctrl_pkg::*;

    localparam int unsigned OS = 4;
    localparam int unsigned FS = 6;
    localparam int unsigned NB = 16;

    typedef struct {
        int cyc;
        bit zero;
        bit valid;
        bit prbs;
        int cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    tx_seq_ctrl_if #(.NB_CNT(NB)) bus ();

    tx_seq_ctrl #(.OS_FACTOR(OS), .FLUSH_SYMS(FS), .NB_CNT(NB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Expected strobe cycles derived from the enable drive point n
    function automatic int run_cyc(input int n, input int j);
        return n + (1 + FS) * OS + 1 + OS * (j - 1);
    endfunction

    task automatic push_flush(input int n);
        for (int k = 0; k < FS; k++) exp_q.push_back('{n + 1 + OS + OS * k, 1'b1, 1'b0, 1'b0, 0});
    endtask

    task automatic push_run(input int n, input int j0, input int j1);
        for (int j = j0; j <= j1; j++) exp_q.push_back('{run_cyc(n, j), 1'b0, 1'b1, 1'b1, j});
    endtask

    task automatic push_drain(input int rlast, input int cnt);
        for (int k = 1; k <= FS; k++) exp_q.push_back('{rlast + OS * k, 1'b1, 1'b1, 1'b0, cnt});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL strobe_missing: no o_tx_ce at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (bus.o_prbs_ce === 1'b1) begin
                n_checks++;
                if (bus.o_tx_ce !== 1'b1) begin
                    n_errors++;
                    $display("FAIL prbs_align: cycle %0d o_tx_ce=%b, required 1 with o_prbs_ce", cyc, bus.o_tx_ce);
                end
            end
            if (bus.o_tx_ce === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_errors++;
                    $display("FAIL strobe_unexpected: o_tx_ce at cycle %0d, next expected %0d",
                             cyc, (exp_q.size() > 0) ? exp_q[0].cyc : -1);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.o_tx_zero, bus.o_tx_valid, bus.o_prbs_ce} !== {e.zero, e.valid, e.prbs} ||
                        bus.o_sym_cnt !== NB'(e.cnt)) begin
                        n_errors++;
                        $display("FAIL strobe_fields: cycle %0d zero/valid/prbs=%b%b%b cnt=%0d, required %b%b%b cnt=%0d",
                                 cyc, bus.o_tx_zero, bus.o_tx_valid, bus.o_prbs_ce, bus.o_sym_cnt,
                                 e.zero, e.valid, e.prbs, e.cnt);
                    end
                end
            end
        end
    endtask

    task automatic check_state(input string name, input logic [ST_W-1:0] want);
        n_checks++;
        if (bus.o_state !== want) begin
            n_errors++;
            $display("FAIL %s: cycle %0d o_state=%0d, required %0d", name, cyc, bus.o_state, want);
        end
    endtask

    task automatic test_reset();
        logic [22:0] snap;
        rst = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_phase  = 2'd0;
`ifdef TX_SEQ_BURST_EN
        bus.i_burst_len = '0;
`endif
        repeat (3) begin
            @(negedge clk);
            snap = {bus.o_state, bus.o_prbs_ce, bus.o_tx_ce, bus.o_tx_zero, bus.o_tx_valid,
                    bus.o_rx_ce, bus.o_sym_cnt};
            n_checks++;
            if (snap !== 23'd0) begin
                n_errors++;
                $display("FAIL reset_outputs: cycle %0d outputs=%h, required 0", cyc, snap);
            end
        end
        rst = 1'b1;
        bus.i_enable = 1'b0;
    endtask

    // Startup: 6 zero strobes, then RUN with prbs on every tx strobe; returns the drive point
    task automatic test_flush_run(output int n);
        repeat (2) @(negedge clk);
        check_state("idle_before_start", 2'd0);
        n = cyc;
        bus.i_enable = 1'b1;
        push_flush(n);
        push_run(n, 1, 20);
        @(negedge clk);
        check_state("flush_entry", 2'd1);
        wait_until(n + 24);
        check_state("flush_last_cycle", 2'd1);
        wait_until(n + 25);
        check_state("run_entry", 2'd2);
        wait_until(run_cyc(n, 20));
        n_checks++;
        if (bus.o_sym_cnt !== 16'd20) begin
            n_errors++;
            $display("FAIL sym_cnt_20: o_sym_cnt=%0d, required 20", bus.o_sym_cnt);
        end
    endtask

    // Mid-symbol drop completes symbol 21, drains, and a re-enable during DRAIN waits for IDLE
    task automatic test_drain_restart(input int n, output int n2);
        int r21;
        wait_until(run_cyc(n, 20) + 1);
        bus.i_enable = 1'b0;
        r21 = run_cyc(n, 21);
        push_run(n, 21, 21);
        push_drain(r21, 21);
        wait_until(r21);
        check_state("drain_entry", 2'd3);
        wait_until(r21 + 6);
        bus.i_enable = 1'b1;
        bus.i_phase  = 2'd2;
        wait_until(r21 + 23);
        check_state("drain_ignores_enable", 2'd3);
        wait_until(r21 + 24);
        check_state("idle_after_drain", 2'd0);
        n_checks++;
        if (bus.o_sym_cnt !== 16'd21) begin
            n_errors++;
            $display("FAIL sym_cnt_21: o_sym_cnt=%0d, required 21", bus.o_sym_cnt);
        end
        n2 = r21 + 24;
        push_flush(n2);
        wait_until(r21 + 25);
        check_state("restart_flush", 2'd1);
        n_checks++;
        if ({bus.o_sym_cnt, bus.o_tx_zero, bus.o_tx_valid} !== 18'd0) begin
            n_errors++;
            $display("FAIL restart_idle_cycle: sym_cnt=%0d zero=%b valid=%b, required 0 0 0",
                     bus.o_sym_cnt, bus.o_tx_zero, bus.o_tx_valid);
        end
    endtask

    // rx strobe follows the latched phase; a mid-symbol change applies from the next symbol
    task automatic test_phase(input int n);
        int  t;
        int  r7;
        logic want;
        push_run(n, 1, 7);
        t = run_cyc(n, 3);
        wait_until(t);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            want = (k == 3 || k == 8 || k == 12);
            n_checks++;
            if (bus.o_rx_ce !== want) begin
                n_errors++;
                $display("FAIL rx_phase: symbol offset %0d o_rx_ce=%b, required %b", k, bus.o_rx_ce, want);
            end
            if (k == 1) bus.i_phase = 2'd3;
        end
        r7 = run_cyc(n, 7);
        wait_until(r7 - 1);
        bus.i_enable = 1'b0;
        push_drain(r7, 7);
        wait_until(r7 + 24);
        check_state("idle_after_phase_run", 2'd0);
    endtask

    task automatic test_reset_in_drain();
        int n;
        int r2;
        logic [22:0] snap;
        repeat (2) @(negedge clk);
        n = cyc;
        bus.i_enable = 1'b1;
        push_flush(n);
        push_run(n, 1, 2);
        r2 = run_cyc(n, 2);
        wait_until(r2 - 1);
        bus.i_enable = 1'b0;
        push_drain(r2, 2);
        wait_until(r2 + 12);
        check_state("drain_before_reset", 2'd3);
        rst = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > r2 + 12) void'(exp_q.pop_back());
        @(negedge clk);
        snap = {bus.o_state, bus.o_prbs_ce, bus.o_tx_ce, bus.o_tx_zero, bus.o_tx_valid,
                bus.o_rx_ce, bus.o_sym_cnt};
        n_checks++;
        if (snap !== 23'd0) begin
            n_errors++;
            $display("FAIL reset_in_drain: outputs=%h, required 0", snap);
        end
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            n_checks++;
            if ({bus.o_state, bus.o_tx_ce, bus.o_prbs_ce, bus.o_rx_ce, bus.o_tx_valid} !== 6'd0) begin
                n_errors++;
                $display("FAIL quiet_after_reset: cycle %0d state=%0d tx_ce=%b prbs=%b rx=%b valid=%b, required all 0",
                         cyc, bus.o_state, bus.o_tx_ce, bus.o_prbs_ce, bus.o_rx_ce, bus.o_tx_valid);
            end
        end
    endtask

`ifdef TX_SEQ_BURST_EN
    task automatic test_burst();
        int n;
        int r5;
        n = cyc;
        bus.i_burst_len = 16'd5;
        bus.i_enable    = 1'b1;
        push_flush(n);
        push_run(n, 1, 5);
        r5 = run_cyc(n, 5);
        push_drain(r5, 5);
        wait_until(r5);
        check_state("burst_drain", 2'd3);
        wait_until(r5 + 24);
        check_state("burst_idle", 2'd0);
        repeat (20) @(negedge clk);
        check_state("burst_no_restart", 2'd0);
        bus.i_enable = 1'b0;
        @(negedge clk);
        bus.i_enable = 1'b1;
        @(negedge clk);
        check_state("burst_restart", 2'd1);
        rst = 1'b0;
        bus.i_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        int n;
        int n2;
        fork
            run_monitor();
        join_none
        test_reset();
        test_flush_run(n);
        test_drain_restart(n, n2);
        test_phase(n2);
        test_reset_in_drain();
`ifdef TX_SEQ_BURST_EN
        test_burst();
`endif
        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drained: %0d expected strobes outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
